// File: rtl/weight_seq_ctrl.sv
// Weight ROM sequencer: sweeps the ROM N_PASSES times and streams
// every coefficient into an ap_fifo port with full backpressure.
module weight_seq_ctrl #(
  parameter int MEM_SIZE   = 1152,
  parameter int DATA_WIDTH = 16,
  parameter int N_PASSES   = 1,
  parameter int ADDR_WIDTH =
    (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [ADDR_WIDTH-1:0] rom_address0,
  output logic                  rom_ce0,
  input  logic [DATA_WIDTH-1:0] rom_q0,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  localparam int PW = $clog2(N_PASSES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [PW-1:0] LAST_P = PW'(N_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   b0_q, b0_d;
  logic [DATA_WIDTH-1:0]   b1_q, b1_d;

  logic       pop;
  logic [2:0] occ;
  logic [1:0] slot;
  logic       last_rd;

  // occupancy the buffer will have next cycle before any new read
  assign pop  = (cnt_q != 2'd0) && output_V_full_n;
  assign occ  = {1'b0, cnt_q} + {2'b0, inflight_q}
              - {2'b0, pop};
  assign slot = cnt_q - {1'b0, pop};
  assign last_rd = rom_ce0 && (addr_q == LAST_A)
                && (pass_q == LAST_P);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (last_rd) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!inflight_q && (cnt_q == 2'd0 ||
            (cnt_q == 2'd1 && pop)))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle        = (state_q == S_IDLE);
    ap_done        = (state_q == S_DONE);
    rom_ce0        = (state_q == S_RUN) && (occ < 3'd2);
    rom_address0   = addr_q;
    output_V_write = pop;
    output_V_din   = b0_q;
  end

  always_comb begin
    addr_d     = addr_q;
    pass_d     = pass_q;
    inflight_d = rom_ce0;
    cnt_d      = 2'(occ);
    b0_d       = b0_q;
    b1_d       = b1_q;
    if (state_q == S_IDLE && ap_start) begin
      addr_d = '0;
      pass_d = '0;
    end else if (rom_ce0) begin
      if (addr_q == LAST_A) begin
        addr_d = '0;
        pass_d = pass_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    if (pop) b0_d = b1_q;
    if (inflight_q) begin
      if (slot == 2'd0) b0_d = rom_q0;
      else              b1_d = rom_q0;
    end
  end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Bench for weight_seq_ctrl: four instances with different ROM
// shapes, a ROM model and a stream monitor feeding per-test checks.
module tb_weight_seq_ctrl;

  function automatic int ms_of(input int g);
    case (g)
      0: return 8;
      1: return 4;
      2: return 1152;
      default: return 1;
    endcase
  endfunction

  function automatic int np_of(input int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic [3:0]  rst_n, start, full_n, clr;
  logic [3:0]  idle, done, ce0, wr;
  logic [15:0] din [4];
  logic [15:0] q0 [4];
  logic [10:0] addr_w [4];
  logic [15:0] rom [4][1152];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  int wr_cnt [4], rd_cnt [4], done_cnt [4];
  int viol_w [4], viol_ce [4], viol_addr [4];
  int max_out [4], first_ce [4], first_wr [4];
  int last_wr [4], done_cyc [4];
  logic [15:0] obs [4][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int M  = ms_of(g);
    localparam int AW = (M > 1) ? $clog2(M) : 1;
    logic [AW-1:0] a;
    weight_seq_ctrl #(
      .MEM_SIZE(M), .DATA_WIDTH(16), .N_PASSES(np_of(g))
    ) u_dut (
      .ap_clk(clk), .ap_rst_n(rst_n[g]),
      .ap_start(start[g]), .ap_idle(idle[g]),
      .ap_done(done[g]), .rom_address0(a),
      .rom_ce0(ce0[g]), .rom_q0(q0[g]),
      .output_V_din(din[g]),
      .output_V_full_n(full_n[g]),
      .output_V_write(wr[g])
    );
    assign addr_w[g] = 11'(a);
  end

  // synchronous ROM with one cycle of read latency
  always @(posedge clk)
    for (int g = 0; g < 4; g++)
      if (ce0[g]) q0[g] <= rom[g][addr_w[g]];

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      int o;
      if (clr[g]) begin
        wr_cnt[g] = 0; rd_cnt[g] = 0; done_cnt[g] = 0;
        viol_w[g] = 0; viol_ce[g] = 0; viol_addr[g] = 0;
        max_out[g] = 0; first_ce[g] = 0; first_wr[g] = 0;
        last_wr[g] = 0; done_cyc[g] = 0;
      end else if (rst_n[g]) begin
        o = rd_cnt[g] - wr_cnt[g];
        if (ce0[g]) begin
          if (int'(addr_w[g]) != rd_cnt[g] % ms_of(g))
            viol_addr[g]++;
          if (o - int'(wr[g]) >= 2) viol_ce[g]++;
          if (rd_cnt[g] == 0) first_ce[g] = cyc;
          rd_cnt[g]++;
        end
        if (wr[g]) begin
          if (!full_n[g]) viol_w[g]++;
          if (wr_cnt[g] < 4096) obs[g][wr_cnt[g]] = din[g];
          if (wr_cnt[g] == 0) first_wr[g] = cyc;
          last_wr[g] = cyc;
          wr_cnt[g]++;
        end
        if (done[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        o = rd_cnt[g] - wr_cnt[g];
        if (o > max_out[g]) max_out[g] = o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear(input int g);
    clr[g] = 1'b1;
    @(negedge clk);
    #1 clr[g] = 1'b0;
  endtask

  task automatic go(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int k = 0;
    while (done_cnt[g] == 0 && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #12;
    for (int g = 0; g < 4; g++) begin
      n_cmp++;
      if ({idle[g], done[g], ce0[g], wr[g]} !== 4'b1000 ||
          addr_w[g] !== 11'd0 || din[g] !== 16'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: idle/done/ce/wr=%b%b%b%b addr=%0h din=%0h, required 1000 0 0",
          g, idle[g], done[g], ce0[g], wr[g],
          addr_w[g], din[g]);
      end
    end
    #5 rst_n = 4'hf;
    tick();
  endtask

  task automatic test_single();
    clear(0);
    full_n[0] = 1'b1;
    go(0);
    wait_done(0, 100);
    n_cmp++;
    if (wr_cnt[0] != 8 || done_cnt[0] != 1) begin
      n_err++;
      $display("FAIL single_count: writes=%0d done=%0d, required 8 1",
        wr_cnt[0], done_cnt[0]);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs[0][i] !== rom[0][i % 8]) begin
        n_err++;
        $display("FAIL single_data[%0d]: got %0h, required %0h",
          i, obs[0][i], rom[0][i % 8]);
      end
    end
    n_cmp++;
    if (first_wr[0] - first_ce[0] != 2) begin
      n_err++;
      $display("FAIL single_latency: got %0d, required 2",
        first_wr[0] - first_ce[0]);
    end
    n_cmp++;
    if (last_wr[0] - first_wr[0] != 7) begin
      n_err++;
      $display("FAIL single_burst: span %0d, required 7",
        last_wr[0] - first_wr[0]);
    end
    n_cmp++;
    if (done_cyc[0] - last_wr[0] != 1 || idle[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: gap %0d idle %b, required 1 1",
        done_cyc[0] - last_wr[0], idle[0]);
    end
  endtask

  task automatic test_passes();
    clear(1);
    full_n[1] = 1'b1;
    go(1);
    wait_done(1, 100);
    n_cmp++;
    if (wr_cnt[1] != 12 || done_cnt[1] != 1) begin
      n_err++;
      $display("FAIL passes_count: writes=%0d done=%0d, required 12 1",
        wr_cnt[1], done_cnt[1]);
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (obs[1][i] !== rom[1][i % 4]) begin
        n_err++;
        $display("FAIL passes_data[%0d]: got %0h, required %0h",
          i, obs[1][i], rom[1][i % 4]);
      end
    end
    n_cmp++;
    if (last_wr[1] - first_wr[1] != 11 || viol_addr[1] != 0) begin
      n_err++;
      $display("FAIL passes_bubble: span %0d addr errs %0d, required 11 0",
        last_wr[1] - first_wr[1], viol_addr[1]);
    end
  endtask

  task automatic test_random_stall();
    int k = 0;
    int bad = 0;
    clear(2);
    full_n[2] = 1'b1;
    go(2);
    while (done_cnt[2] == 0 && k < 8000) begin
      full_n[2] = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    full_n[2] = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (wr_cnt[2] != 1152 || done_cnt[2] != 1) begin
      n_err++;
      $display("FAIL rand_count: writes=%0d done=%0d, required 1152 1",
        wr_cnt[2], done_cnt[2]);
    end
    for (int i = 0; i < 1152; i++) begin
      n_cmp++;
      if (obs[2][i] !== rom[2][i] && bad < 10) begin
        bad++;
        n_err++;
        $display("FAIL rand_data[%0d]: got %0h, required %0h",
          i, obs[2][i], rom[2][i]);
      end
    end
    n_cmp++;
    if (viol_w[2] + viol_ce[2] + viol_addr[2] != 0 ||
        max_out[2] > 2) begin
      n_err++;
      $display("FAIL rand_rules: wr/ce/addr errs %0d %0d %0d max %0d, required 0 0 0 <=2",
        viol_w[2], viol_ce[2], viol_addr[2], max_out[2]);
    end
  endtask

  task automatic test_stall();
    int w0;
    int bad = 0;
    clear(2);
    full_n[2] = 1'b1;
    go(2);
    repeat (40) tick();
    full_n[2] = 1'b0;
    w0 = wr_cnt[2];
    repeat (20) tick();
    n_cmp++;
    if (wr_cnt[2] != w0 || rd_cnt[2] - wr_cnt[2] != 2 ||
        ce0[2] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: writes %0d->%0d outstanding %0d ce0 %b, required same 2 0",
        w0, wr_cnt[2], rd_cnt[2] - wr_cnt[2], ce0[2]);
    end
    full_n[2] = 1'b1;
    wait_done(2, 3000);
    n_cmp++;
    if (wr_cnt[2] != 1152 || max_out[2] > 2) begin
      n_err++;
      $display("FAIL stall_count: writes=%0d max %0d, required 1152 <=2",
        wr_cnt[2], max_out[2]);
    end
    for (int i = w0 - 2; i < w0 + 4; i++) begin
      n_cmp++;
      if (obs[2][i] !== rom[2][i] && bad < 10) begin
        bad++;
        n_err++;
        $display("FAIL stall_resume[%0d]: got %0h, required %0h",
          i, obs[2][i], rom[2][i]);
      end
    end
  endtask

  task automatic test_restart_ignore();
    int busy_err = 0;
    clear(0);
    full_n[0] = 1'b1;
    start[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) full_n[0] = 1'b0;
      tick();
      if (idle[0] !== 1'b0 || done[0] !== 1'b0) busy_err++;
    end
    start[0] = 1'b0;
    full_n[0] = 1'b1;
    wait_done(0, 100);
    repeat (15) tick();
    n_cmp++;
    if (done_cnt[0] != 1 || wr_cnt[0] != 8 || busy_err != 0) begin
      n_err++;
      $display("FAIL restart_ignore: done=%0d writes=%0d busy errs=%0d, required 1 8 0",
        done_cnt[0], wr_cnt[0], busy_err);
    end
    n_cmp++;
    if (obs[0][7] !== rom[0][7] || idle[0] !== 1'b1) begin
      n_err++;
      $display("FAIL restart_last: got %0h idle %b, required %0h 1",
        obs[0][7], idle[0], rom[0][7]);
    end
  endtask

  task automatic test_async_reset();
    clear(0);
    full_n[0] = 1'b1;
    go(0);
    repeat (4) tick();
    n_cmp++;
    if (wr[0] !== 1'b1 || ce0[0] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: wr %b ce0 %b, required 1 1",
        wr[0], ce0[0]);
    end
    #2 rst_n[0] = 1'b0;
    #1;
    n_cmp++;
    if ({wr[0], ce0[0], done[0], idle[0]} !== 4'b0001) begin
      n_err++;
      $display("FAIL arst_drop: wr/ce/done/idle=%b%b%b%b, required 0001",
        wr[0], ce0[0], done[0], idle[0]);
    end
    repeat (2) @(negedge clk);
    #2 rst_n[0] = 1'b1;
    tick();
    n_cmp++;
    if (idle[0] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_idle: got %b, required 1", idle[0]);
    end
    clear(0);
    go(0);
    wait_done(0, 100);
    n_cmp++;
    if (wr_cnt[0] != 8 || obs[0][0] !== rom[0][0] ||
        viol_addr[0] != 0) begin
      n_err++;
      $display("FAIL arst_replay: writes %0d first %0h addr errs %0d, required 8 %0h 0",
        wr_cnt[0], obs[0][0], viol_addr[0], rom[0][0]);
    end
  endtask

  task automatic test_mem1();
    clear(3);
    full_n[3] = 1'b1;
    go(3);
    wait_done(3, 50);
    n_cmp++;
    if (wr_cnt[3] != 2 || done_cnt[3] != 1 ||
        viol_addr[3] != 0) begin
      n_err++;
      $display("FAIL mem1_count: writes %0d done %0d addr errs %0d, required 2 1 0",
        wr_cnt[3], done_cnt[3], viol_addr[3]);
    end
    n_cmp++;
    if (obs[3][0] !== rom[3][0] || obs[3][1] !== rom[3][0]) begin
      n_err++;
      $display("FAIL mem1_data: got %0h %0h, required %0h",
        obs[3][0], obs[3][1], rom[3][0]);
    end
  endtask

  initial begin
    rst_n  = 4'h0;
    start  = 4'h0;
    full_n = 4'hf;
    clr    = 4'h0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < ms_of(g); i++)
        rom[g][i] = (g == 2) ? 16'($urandom) : 16'(i + 1);
    test_reset();
    for (int g = 0; g < 4; g++) clear(g);
    test_single();
    test_passes();
    test_random_stall();
    test_stall();
    test_restart_ignore();
    test_async_reset();
    test_mem1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
